// File: rtl/seq_scan_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the bit-serial pattern scanner.
package seq_scan_ctrl_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefPatW  = 4;
  localparam int unsigned DefCntW  = 8;
  localparam int unsigned LenW     = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/pat_detector.sv
// Sliding-window pattern detector: Mealy hit when the newest PAT_W bits equal the pattern.
module pat_detector
  import seq_scan_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = DefPatW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int unsigned SeenW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist_q, hist_d, hist_next;
  logic [SeenW-1:0] seen_q, seen_d;

  assign hist_next = (hist_q << 1) | PAT_W'(bit_in);

  always_comb begin
    hist_d = hist_q;
    seen_d = seen_q;
    hit    = 1'b0;
    if (clr) begin
      hist_d = '0;
      seen_d = '0;
    end else if (bit_valid) begin
      hist_d = hist_next;
      if (seen_q != SeenW'(PAT_W)) seen_d = seen_q + 1'b1;
      // PAT_W-1 earlier bits plus the current one fill the window
      hit = (seen_q >= SeenW'(PAT_W - 1)) && (hist_next == pattern);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      seen_q <= '0;
    end else begin
      hist_q <= hist_d;
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Loads words over a valid/ready handshake, shifts them out MSB first and counts pattern hits.
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned PAT_W  = DefPatW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LenW-1:0]   len,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_count,
  output logic              done
);

  localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e              state_q, state_d;
  logic [LenW-1:0]     left_q;
  logic [PAT_W-1:0]    pat_q;
  logic [DATA_W-1:0]   word_q;
  logic [BitCntW-1:0]  bit_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                accept, handshake, shifting, last_bit, det_hit;

  assign accept    = (state_q == StIdle) && start;
  assign handshake = (state_q == StLoad) && in_valid;
  assign shifting  = (state_q == StShift);
  assign last_bit  = shifting && (bit_q == BitCntW'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (len == '0) ? StDone : StLoad;
      StLoad:  if (in_valid) state_d = StShift;
      StShift: if (last_bit) state_d = (left_q != '0) ? StLoad : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StLoad);
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
  end

  // left_q counts words not yet handshaken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_q <= '0;
      pat_q  <= '0;
      word_q <= '0;
      bit_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        left_q <= len;
        pat_q  <= cfg_pattern;
        cnt_q  <= '0;
      end
      if (handshake) begin
        word_q <= in_data;
        bit_q  <= '0;
        left_q <= left_q - 1'b1;
      end
      if (shifting) begin
        word_q <= word_q << 1;
        bit_q  <= bit_q + 1'b1;
        if (det_hit && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  pat_detector #(
    .PAT_W(PAT_W)
  ) u_pat_detector (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .bit_valid(shifting),
    .bit_in   (word_q[DATA_W-1]),
    .pattern  (pat_q),
    .hit      (det_hit)
  );

  assign hit       = det_hit;
  assign hit_count = cnt_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Randomized and directed jobs checked against a bit-list reference model of the scanner.
module tb_seq_scan_ctrl;

  localparam int DW     = 8;
  localparam int PW     = 4;
  localparam int CntMax = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic [3:0] cfg_pattern = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, busy, hit, done;
  logic [7:0] hit_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] words[$];

  seq_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .cfg_pattern(cfg_pattern),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .hit        (hit),
    .hit_count  (hit_count),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"}, int'(in_ready), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_hit"}, int'(hit), 0);
    check_eq({tag, "_done"}, int'(done), 0);
    check_eq({tag, "_hit_count"}, int'(hit_count), 0);
  endtask

  // Called at a negedge; drives start immediately. exp_cnt < 0 means use the model count.
  task automatic run_job(input logic [3:0] pat, input int exp_cnt, input int stall_max,
                         input bit noise);
    int nwords, nbits, total, expected, cyc, bi, wi, run, stall_left, stalls;
    bit bits[$];
    bit exp_hit[$];
    bit match, saw_ready, done_seen, shift_now;

    nwords = words.size();
    nbits  = nwords * DW;
    total  = 0;
    for (int w = 0; w < nwords; w++)
      for (int b = DW - 1; b >= 0; b--) bits.push_back(words[w][b]);
    for (int i = 0; i < nbits; i++) begin
      match = 1'b0;
      if (i >= PW - 1) begin
        match = 1'b1;
        for (int k = 0; k < PW; k++)
          if (bits[i-PW+1+k] != pat[PW-1-k]) match = 1'b0;
      end
      exp_hit.push_back(match);
      if (match) total++;
    end
    expected = (exp_cnt >= 0) ? exp_cnt : ((total > CntMax) ? CntMax : total);

    start       = 1'b1;
    len         = 8'(nwords);
    cfg_pattern = pat;
    in_valid    = 1'b0;
    cyc = 0; bi = 0; wi = 0; run = 0; stalls = 0;
    stall_left = $urandom_range(stall_max, 0);
    saw_ready = 1'b0;
    done_seen = 1'b0;

    while (!done_seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      shift_now = busy && !in_ready && !done;
      start       = noise && shift_now && ($urandom_range(1, 0) == 1);
      len         = noise ? 8'($urandom) : 8'(nwords);
      cfg_pattern = noise ? 4'($urandom) : pat;
      if (in_ready) saw_ready = 1'b1;
      check_eq("hit_count_running", int'(hit_count), (run > CntMax) ? CntMax : run);
      if (shift_now) begin
        if (bi < nbits) begin
          check_eq($sformatf("hit_bit%0d", bi), int'(hit), int'(exp_hit[bi]));
          if (exp_hit[bi]) run++;
        end else begin
          check_eq("extra_shift_bit", bi, nbits - 1);
        end
        bi++;
      end else begin
        check_eq("hit_outside_shift", int'(hit), 0);
      end
      if (done) begin
        done_seen = 1'b1;
        check_eq("done_cycle", cyc, 1 + nwords * (DW + 1) + stalls);
        check_eq("bits_shifted", bi, nbits);
        check_eq("count_at_done", int'(hit_count), expected);
        check_eq("busy_in_done", int'(busy), 1);
        if (nwords == 0) check_eq("ready_seen_len0", int'(saw_ready), 0);
        start    = 1'b0;
        in_valid = 1'b0;
      end else if (in_ready) begin
        if (stall_left > 0) begin
          in_valid = 1'b0;
          stall_left--;
          stalls++;
        end else begin
          in_valid   = 1'b1;
          in_data    = (wi < nwords) ? words[wi] : 8'h00;
          wi++;
          stall_left = $urandom_range(stall_max, 0);
        end
      end else begin
        in_valid = noise ? 1'($urandom) : 1'b1;
        in_data  = 8'($urandom);
      end
    end
    check_eq("done_reached", int'(done_seen), 1);

    @(negedge clk);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_done", int'(done), 0);
    check_eq("count_held", int'(hit_count), expected);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Overlapping hits at bit indices 3, 5, 7
    words = {8'h55};
    run_job(4'b0101, 3, 0, 1'b0);

    // Match across the word boundary
    words = {8'h02, 8'h80};
    run_job(4'b0101, 1, 0, 1'b0);

    words = {};
    run_job(4'b0101, 0, 0, 1'b0);

    // Stall between words must not change the count
    words = {8'h02, 8'h80};
    run_job(4'b0101, 1, 3, 1'b0);
    words = {8'h5A, 8'hA5};
    run_job(4'b1010, -1, 3, 1'b0);

    // start and cfg_pattern/len noise during the job
    words = {8'h55, 8'h55};
    run_job(4'b0101, 7, 0, 1'b1);

    // Saturation: 40 zero words against pattern 0000
    words = {};
    for (int i = 0; i < 40; i++) words.push_back(8'h00);
    run_job(4'b0000, 255, 0, 1'b0);

    // Asynchronous reset mid-SHIFT
    words = {8'hFF};
    start = 1'b1; len = 8'd1; cfg_pattern = 4'b1111; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre_reset_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    words = {8'h55};
    run_job(4'b0101, 3, 0, 1'b0);

    for (int j = 0; j < 25; j++) begin
      int nw;
      nw = $urandom_range(4, 0);
      words = {};
      for (int w = 0; w < nw; w++) words.push_back(8'($urandom));
      run_job(4'($urandom), -1, $urandom_range(3, 0), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of each input word.
REQ-002 Parameter PAT_W, default 4, SHALL set the width of the pattern to detect.
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the hit counter.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 start  input  1  SHALL request a new job; sampled only in IDLE.
REQ-007 len  input  8  SHALL give the job's word count; sampled with start.
REQ-008 cfg_pattern  input  PAT_W  SHALL give the pattern to detect; sampled with start; the first-received bit is the MSB.
REQ-009 in_valid  input  1  SHALL mark in_data as valid.
REQ-010 in_data  input  DATA_W  SHALL carry the data word, shifted out MSB first.
REQ-011 in_ready  output  1  SHALL be high only in LOAD.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 hit  output  1  SHALL pulse in each cycle where the current bit completes a match.
REQ-014 hit_count  output  CNT_W  SHALL give the number of matches in the current or last job.
REQ-015 done  output  1  SHALL be a one-cycle pulse in DONE.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-017 IDLE with start=1: latch len and cfg_pattern, clear hit_count and detector history; go to DONE if len=0, else to LOAD.
REQ-018 LOAD: an in_valid&&in_ready handshake captures in_data and goes to SHIFT; with in_valid=0 it SHALL wait with no state change.
REQ-019 SHIFT: present exactly one bit per cycle, MSB first, for DATA_W cycles; after the last bit go to LOAD if words remain, else DONE.
REQ-020 DONE SHALL last exactly one cycle, assert done, and then go to IDLE.
REQ-021 Latency: a 1-word job SHALL assert done at cycle 2+DATA_W after the start cycle when in_valid is held high (start at cycle 0, handshake at cycle 1, shift at cycles 2..9, done at cycle 10 for DATA_W=8).
REQ-022 Detector: the last PAT_W bits presented are kept in history; hit = (at least PAT_W bits seen this job) && (history including the current bit == latched pattern); the output is Mealy, same cycle.
REQ-023 Overlapping matches SHALL each be counted.
REQ-024 Matches spanning word boundaries SHALL be counted; history SHALL be kept across LOAD stalls of any length.
REQ-025 History SHALL NOT span jobs; it is cleared at start.
REQ-026 hit_count SHALL increment by 1 per hit, saturate at all-ones, and hold its value after DONE until the next accepted start.
REQ-027 start in any state other than IDLE SHALL be ignored; changes to cfg_pattern or len mid-job SHALL be ignored.
REQ-028 hit SHALL be 0 outside SHIFT.

Reset
REQ-029 When rst=0, the block SHALL immediately enter IDLE, including mid-job.
REQ-030 While rst=0: in_ready=0, busy=0, hit=0, done=0, hit_count=0, and history and the latched pattern, len and word are cleared.
REQ-031 After rst is released, the block SHALL accept start on the first rising edge.

Structure
REQ-032 A shared package SHALL hold the state encoding constants (IDLE, LOAD, SHIFT, DONE; 2 bits) and the parameter defaults.
REQ-033 The detector SHALL be one sub-module, pat_detector (inputs clk, rst, clr, bit_valid, bit_in, pattern; output hit), instantiated once.
REQ-034 The target size SHALL be 150-300 lines of RTL in total.

Verification
REQ-035 Pattern 4'b0101, len=1, word 8'b0101_0101 SHALL give hit at bit indices 3, 5 and 7, with hit_count=3 at done.
REQ-036 Pattern 4'b0101, len=2, words 8'b0000_0010 then 8'b1000_0000 SHALL give a single hit on bit 0 of word 2, with hit_count=1.
REQ-037 len=0 with start at cycle 0 SHALL give done=1 at cycle 1, hit_count=0, and in_ready never high.
REQ-038 len=2 with in_valid low for 3 cycles between words SHALL keep in_ready=1 and hit_count unchanged during the stall, and give the same final count as a job without the stall.
REQ-039 rst=0 for 1 cycle during SHIFT SHALL set all outputs to 0 in the same cycle; a fresh job with word 8'b0101_0101 SHALL then give hit_count=3.
REQ-040 start pulsed during SHIFT, and cfg_pattern changed mid-job, SHALL have no effect on state or count.
